rotate16_sequencer: RTL and testbench
=====================================

Name: rotate16_sequencer

Overview:
- Command sequencer that sits directly upstream of the 16-bit barrel shifter stage.
- Accepts full 16-bit rotate requests with amount 0..15 over a valid/ready handshake.
- The shifter stage rotates by at most 7 per operation, so the sequencer splits each request into 1-3 passes, driving the shifter's enable/write/direction/input/coeff ports and looping its result back as the next pass's input.
- Returns the final rotated word to a downstream consumer over a valid/ready handshake.

Parameters:
- WRITE_CYCLES, 2: cycles per pass with shifter write phase asserted (min 1).
- SHIFT_CYCLES, 3: cycles per pass with enable high and write low, before the result is captured (min 1).

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous reset, active-high.
- rx_valid  in  1  request valid.
- tx_ready  out  1  sequencer can accept a request.
- rx_data  in  16  word to rotate.
- rx_amount  in  4  rotate amount 0..15.
- rx_direction  in  2  2'b10 = rotate left; 2'b01 = rotate right; 2'b00/2'b11 = pass-through.
- tx_valid  out  1  result valid.
- rx_ready  in  1  downstream accepts result.
- tx_result  out  16  rotated word.
- tx_count  out  16  completed-request counter.
- tx_sh_enable  out  1  shifter enable.
- tx_sh_write  out  1  shifter write (load phase).
- tx_sh_direction  out  2  shifter direction.
- tx_sh_input  out  16  shifter input word.
- tx_sh_coeff  out  3  shifter per-pass amount 0..7.
- rx_sh_result  in  16  shifter output.

Behaviour:
- Reset (areset high at an edge):
  - State goes to IDLE; any in-flight request is dropped.
  - tx_valid, tx_result, tx_count, all tx_sh_* and the internal work/remaining registers clear to 0.
  - tx_ready is 1 from the first cycle after reset deasserts.
- States: IDLE, LOAD, SHIFT, CAPTURE, DONE.
- IDLE:
  - tx_ready = 1 (only in IDLE).
  - On rx_valid & tx_ready, latch data into the work register, plus amount and direction.
  - Bypass case (direction is 2'b00/2'b11, or amount = 0): tx_result <= rx_data and go to DONE. No shifter activity.
  - Otherwise go to LOAD with remaining = amount.
- Pass coefficient: coeff = min(remaining, 7). Passes = 1 for amount 1-7, 2 for 8-14, 3 for 15 (7+7+1).
- LOAD:
  - Lasts WRITE_CYCLES cycles.
  - tx_sh_enable = 1, tx_sh_write = 1.
  - tx_sh_input = work, tx_sh_coeff = coeff, tx_sh_direction = latched direction.
- SHIFT:
  - Lasts SHIFT_CYCLES cycles.
  - tx_sh_enable = 1, tx_sh_write = 0; other tx_sh_* held.
- CAPTURE (1 cycle):
  - tx_sh_enable = 0, tx_sh_write = 0; tx_sh_input/coeff/direction held.
  - work <= rx_sh_result; remaining <= remaining - coeff.
  - If the new remaining != 0, go to LOAD.
  - Else tx_result <= rx_sh_result and go to DONE.
- DONE:
  - tx_valid = 1; tx_result held stable while rx_ready = 0.
  - On rx_ready: tx_count <= tx_count + 1 (wraps 0xFFFF -> 0x0000), go to IDLE.
  - tx_valid is 0 and tx_ready is 1 in the next cycle. There is no same-cycle accept of a new request.
- Latency (tx_valid asserted N cycles after the accept cycle):
  - Bypass: N = 1.
  - Otherwise: N = passes*(WRITE_CYCLES+SHIFT_CYCLES+1) + 1. Defaults give 7 / 13 / 19 for 1 / 2 / 3 passes.
- Request inputs are ignored outside IDLE. rx_valid held high while busy must not be double-accepted.
- tx_sh_* outputs are registered, never glitch, and are 0 in IDLE and DONE except input/coeff/direction, which hold their last values.
- The rotated result must equal a true 16-bit rotate. The right-rotate total equals the sum of per-pass right rotates.

Test Plan:
- Reset, then request data 0x8001, left, amount 1 -> tx_valid at cycle 7, tx_result = 0x0003; exactly one LOAD/SHIFT/CAPTURE; tx_sh_coeff = 1; tx_count = 1 after handshake.
- Data 0x0001, left, amount 9 -> two passes (coeff 7 then 2), second pass tx_sh_input = 0x0080, tx_result = 0x0200 at cycle 13.
- Data 0x0001, right, amount 15 -> coeffs 7, 7, 1; tx_result = 0x0002 at cycle 19; tx_ready = 0 throughout and a held rx_valid is not re-accepted.
- Data 0xBEEF, direction 2'b11, amount 5; then 0x1234, left, amount 0 -> both bypass: tx_result 0xBEEF / 0x1234 at cycle 1, tx_sh_enable never asserted.
- Result 0x0003 pending with rx_ready low for 5 cycles -> tx_valid and tx_result stay 0x0003, tx_ready = 0; IDLE follows the cycle after rx_ready rises.
- areset asserted during the SHIFT of a 3-pass request -> next cycle all outputs 0 and tx_ready = 1 after deassert; a new 0x00F0 left-4 request returns 0x0F00 with tx_count = 1.

Source files
------------

// File: rtl/rotate16_sequencer_if.sv
// Request/result handshake bundle for the rotate16 sequencer.
// slave: sequencer side; master: requester and result consumer side.
interface rotate16_sequencer_if;
    logic        rx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic [3:0]  rx_amount;
    logic [1:0]  rx_direction;
    logic        tx_valid;
    logic        rx_ready;
    logic [15:0] tx_result;
    logic [15:0] tx_count;

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  rx_amount,
        input  rx_direction,
        input  rx_ready,
        output tx_ready,
        output tx_valid,
        output tx_result,
        output tx_count
    );

    modport master (
        output rx_valid,
        output rx_data,
        output rx_amount,
        output rx_direction,
        output rx_ready,
        input  tx_ready,
        input  tx_valid,
        input  tx_result,
        input  tx_count
    );
endinterface

// File: rtl/rotate16_sequencer.sv
// Splits 16-bit rotates (0..15) into passes of at most 7 on a shifter stage.
// Ports: aclk, areset (sync, high), bus (request/result), tx_sh_*/rx_sh_result (shifter).
module rotate16_sequencer #(
    parameter int WRITE_CYCLES = 2,
    parameter int SHIFT_CYCLES = 3
) (
    input  logic                  aclk,
    input  logic                  areset,
    rotate16_sequencer_if.slave   bus,
    output logic                  tx_sh_enable,
    output logic                  tx_sh_write,
    output logic [1:0]            tx_sh_direction,
    output logic [15:0]           tx_sh_input,
    output logic [2:0]            tx_sh_coeff,
    input  logic [15:0]           rx_sh_result
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [7:0] WR_LAST = 8'(WRITE_CYCLES - 1);
    localparam logic [7:0] SH_LAST = 8'(SHIFT_CYCLES - 1);

    state_t      state;
    logic [7:0]  phase_cnt;
    logic [3:0]  remaining;
    logic [3:0]  rem_next;
    logic        ready_q;
    logic        valid_q;
    logic [15:0] result_q;
    logic [15:0] count_q;
    logic        bypass;

    function automatic logic [2:0] pass_coeff(input logic [3:0] r);
        return (r > 4'd7) ? 3'd7 : r[2:0];
    endfunction

    // Amount still owed after the pass currently on the shifter.
    assign rem_next = remaining - {1'b0, tx_sh_coeff};

    // Neutral directions and zero amounts never touch the shifter.
    assign bypass = (bus.rx_direction == 2'b00) ||
                    (bus.rx_direction == 2'b11) ||
                    (bus.rx_amount == 4'd0);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state           <= IDLE;
            phase_cnt       <= '0;
            remaining       <= '0;
            ready_q         <= 1'b0;
            valid_q         <= 1'b0;
            result_q        <= '0;
            count_q         <= '0;
            tx_sh_enable    <= 1'b0;
            tx_sh_write     <= 1'b0;
            tx_sh_direction <= '0;
            tx_sh_input     <= '0;
            tx_sh_coeff     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.rx_valid && ready_q) begin
                        ready_q   <= 1'b0;
                        remaining <= bus.rx_amount;
                        if (bypass) begin
                            result_q <= bus.rx_data;
                            valid_q  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            tx_sh_enable    <= 1'b1;
                            tx_sh_write     <= 1'b1;
                            tx_sh_input     <= bus.rx_data;
                            tx_sh_coeff     <= pass_coeff(bus.rx_amount);
                            tx_sh_direction <= bus.rx_direction;
                            phase_cnt       <= WR_LAST;
                            state           <= LOAD;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (phase_cnt == 8'd0) begin
                        tx_sh_write <= 1'b0;
                        phase_cnt   <= SH_LAST;
                        state       <= SHIFT;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                SHIFT: begin
                    if (phase_cnt == 8'd0) begin
                        tx_sh_enable <= 1'b0;
                        state        <= CAPTURE;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                CAPTURE: begin
                    remaining <= rem_next;
                    if (rem_next != 4'd0) begin
                        // Loop the partial result back for another pass.
                        tx_sh_enable <= 1'b1;
                        tx_sh_write  <= 1'b1;
                        tx_sh_input  <= rx_sh_result;
                        tx_sh_coeff  <= pass_coeff(rem_next);
                        phase_cnt    <= WR_LAST;
                        state        <= LOAD;
                    end else begin
                        result_q <= rx_sh_result;
                        valid_q  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rx_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        count_q <= count_q + 16'd1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready  = ready_q;
    assign bus.tx_valid  = valid_q;
    assign bus.tx_result = result_q;
    assign bus.tx_count  = count_q;

endmodule

// File: tb/tb_rotate16_sequencer.sv
// Directed bench for rotate16_sequencer with a behavioural shifter model.
// Checks latency, pass split, results, backpressure, bypass and reset.
module tb_rotate16_sequencer;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        sh_en;
    logic        sh_wr;
    logic [1:0]  sh_dir;
    logic [15:0] sh_in;
    logic [2:0]  sh_coeff;
    logic [15:0] sh_res;

    int          n_chk = 0;
    int          n_fail = 0;
    int          lat;
    int          npass;
    bit          en_seen;
    bit          rdy_seen;
    logic [2:0]  cf [4];
    logic [15:0] pin [4];

    always #5 aclk = ~aclk;

    rotate16_sequencer_if bus ();

    rotate16_sequencer #(
        .WRITE_CYCLES (2),
        .SHIFT_CYCLES (3)
    ) dut (
        .aclk            (aclk),
        .areset          (areset),
        .bus             (bus),
        .tx_sh_enable    (sh_en),
        .tx_sh_write     (sh_wr),
        .tx_sh_direction (sh_dir),
        .tx_sh_input     (sh_in),
        .tx_sh_coeff     (sh_coeff),
        .rx_sh_result    (sh_res)
    );

    // Shifter stage model: true rotate by 0..7.
    function automatic logic [15:0] rot16(input logic [15:0] x,
                                          input logic [2:0] c,
                                          input logic [1:0] d);
        logic [31:0] dbl;
        dbl = {x, x};
        if (d == 2'b10)
            return 16'(dbl >> (16 - int'(c)));
        else if (d == 2'b01)
            return 16'(dbl >> c);
        return x;
    endfunction

    assign sh_res = rot16(sh_in, sh_coeff, sh_dir);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_req(input logic [15:0] d, input logic [3:0] a,
                           input logic [1:0] dir, input bit hold);
        bit prev_w;
        @(negedge aclk);
        check("ready_before_req", 32'(bus.tx_ready), 1);
        bus.rx_valid     = 1'b1;
        bus.rx_data      = d;
        bus.rx_amount    = a;
        bus.rx_direction = dir;
        @(posedge aclk);
        #1;
        if (!hold) bus.rx_valid = 1'b0;
        lat      = 0;
        npass    = 0;
        en_seen  = 1'b0;
        rdy_seen = 1'b0;
        prev_w   = 1'b0;
        while (lat < 100) begin
            @(negedge aclk);
            lat++;
            if (sh_en) en_seen = 1'b1;
            if (sh_wr && !prev_w) begin
                if (npass < 4) begin
                    cf[npass]  = sh_coeff;
                    pin[npass] = sh_in;
                end
                npass++;
            end
            prev_w = sh_wr;
            if (bus.tx_valid) break;
            if (bus.tx_ready) rdy_seen = 1'b1;
        end
        if (lat >= 100) check("valid_timeout", 32'(bus.tx_valid), 1);
    endtask

    task automatic finish_req(input int stall, input logic [15:0] exp_res,
                              input logic [15:0] exp_cnt);
        check("result", 32'(bus.tx_result), 32'(exp_res));
        for (int i = 0; i < stall; i++) begin
            @(negedge aclk);
            check("stall_valid", 32'(bus.tx_valid), 1);
            check("stall_result", 32'(bus.tx_result), 32'(exp_res));
            check("stall_ready", 32'(bus.tx_ready), 0);
        end
        bus.rx_valid = 1'b0;
        bus.rx_ready = 1'b1;
        @(posedge aclk);
        #1;
        bus.rx_ready = 1'b0;
        @(negedge aclk);
        check("post_valid", 32'(bus.tx_valid), 0);
        check("post_ready", 32'(bus.tx_ready), 1);
        check("count", 32'(bus.tx_count), 32'(exp_cnt));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, 32'(bus.tx_valid), 0);
        check({tag, "_result"}, 32'(bus.tx_result), 0);
        check({tag, "_count"}, 32'(bus.tx_count), 0);
        check({tag, "_sh_en"}, 32'(sh_en), 0);
        check({tag, "_sh_wr"}, 32'(sh_wr), 0);
        check({tag, "_sh_in"}, 32'(sh_in), 0);
        check({tag, "_sh_coeff"}, 32'(sh_coeff), 0);
        check({tag, "_sh_dir"}, 32'(sh_dir), 0);
    endtask

    initial begin
        bus.rx_valid     = 1'b0;
        bus.rx_data      = '0;
        bus.rx_amount    = '0;
        bus.rx_direction = '0;
        bus.rx_ready     = 1'b0;
        areset           = 1'b1;
        repeat (2) @(negedge aclk);
        check_cleared("rst");
        areset = 1'b0;
        @(negedge aclk);
        check("rst_ready", 32'(bus.tx_ready), 1);

        // One pass: 0x8001 rol 1.
        run_req(16'h8001, 4'd1, 2'b10, 1'b0);
        check("t1_lat", lat, 7);
        check("t1_passes", npass, 1);
        check("t1_coeff0", 32'(cf[0]), 1);
        finish_req(0, 16'h0003, 16'd1);
        check("t1_sh_dir_hold", 32'(sh_dir), 32'(2'b10));
        check("t1_sh_en_idle", 32'(sh_en), 0);

        // Two passes: 0x0001 rol 9.
        run_req(16'h0001, 4'd9, 2'b10, 1'b0);
        check("t2_lat", lat, 13);
        check("t2_passes", npass, 2);
        check("t2_coeff0", 32'(cf[0]), 7);
        check("t2_coeff1", 32'(cf[1]), 2);
        check("t2_input1", 32'(pin[1]), 32'h0080);
        finish_req(0, 16'h0200, 16'd2);

        // Three passes with rx_valid held: 0x0001 ror 15.
        run_req(16'h0001, 4'd15, 2'b01, 1'b1);
        check("t3_lat", lat, 19);
        check("t3_passes", npass, 3);
        check("t3_coeff0", 32'(cf[0]), 7);
        check("t3_coeff1", 32'(cf[1]), 7);
        check("t3_coeff2", 32'(cf[2]), 1);
        check("t3_input1", 32'(pin[1]), 32'h0200);
        check("t3_input2", 32'(pin[2]), 32'h0004);
        check("t3_ready_busy", 32'(rdy_seen), 0);
        finish_req(0, 16'h0002, 16'd3);

        // Bypass: neutral direction, then zero amount.
        run_req(16'hBEEF, 4'd5, 2'b11, 1'b0);
        check("t4a_lat", lat, 1);
        check("t4a_sh_en", 32'(en_seen), 0);
        finish_req(0, 16'hBEEF, 16'd4);
        run_req(16'h1234, 4'd0, 2'b10, 1'b0);
        check("t4b_lat", lat, 1);
        check("t4b_sh_en", 32'(en_seen), 0);
        finish_req(0, 16'h1234, 16'd5);
        check("t4_sh_in_hold", 32'(sh_in), 32'h0004);

        // Backpressure: hold off rx_ready for 5 cycles.
        run_req(16'h8001, 4'd1, 2'b10, 1'b0);
        check("t5_lat", lat, 7);
        finish_req(5, 16'h0003, 16'd6);

        // Reset in the SHIFT phase of a 3-pass request.
        @(negedge aclk);
        bus.rx_valid     = 1'b1;
        bus.rx_data      = 16'h0001;
        bus.rx_amount    = 4'd15;
        bus.rx_direction = 2'b01;
        @(posedge aclk);
        #1;
        bus.rx_valid = 1'b0;
        repeat (4) @(negedge aclk);
        check("t6_in_shift_en", 32'(sh_en), 1);
        check("t6_in_shift_wr", 32'(sh_wr), 0);
        areset = 1'b1;
        @(negedge aclk);
        check_cleared("t6_rst");
        areset = 1'b0;
        @(negedge aclk);
        check("t6_ready", 32'(bus.tx_ready), 1);
        run_req(16'h00F0, 4'd4, 2'b10, 1'b0);
        check("t6_lat", lat, 7);
        finish_req(0, 16'h0F00, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
